r2mdc_commutator: RTL
=====================

// Module: r2mdc_commutator
// PURPOSE
//  Delay-commutator between two R2MDC pipeline stages. Takes the two complex
//  output lanes of one radix-2 butterfly (upper = sum, lower = twiddled
//  difference) and reorders them into the A/B operand pairs the next stage's
//  butterfly needs. The pairs are spaced DELAY samples apart. Streaming,
//  valid-qualified, with a flush sequence that drains the last frame.
// PARAMETERS
//  DATA_W  16  width of each re/im component, signed Q7.8, passed through unmodified
//  DELAY   4   pair spacing for the next stage (N/4, N/8, ...); power of two, >= 1
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       in_u_* and in_l_* carry one sample pair this cycle
//  in_u_re    in   DATA_W  upper lane real (butterfly Y0)
//  in_u_im    in   DATA_W  upper lane imag
//  in_l_re    in   DATA_W  lower lane real (butterfly Y1)
//  in_l_im    in   DATA_W  lower lane imag
//  flush      in   1       end of stream: drain the stored samples
//  busy       out  1       flush in progress; in_valid is ignored
//  out_valid  out  1       out_a_* and out_b_* hold a valid operand pair
//  out_a_re   out  DATA_W  operand A real (next butterfly A)
//  out_a_im   out  DATA_W  operand A imag
//  out_b_re   out  DATA_W  operand B real (next butterfly B)
//  out_b_im   out  DATA_W  operand B imag
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0, delay lines 0.
//  - An "advance" happens on an accepted pair (in_valid=1 and not busy) or on a FLUSH cycle.
//  - Delay lines and the sample counter change only on an advance. Gaps in in_valid stall everything.
//  - Sample counter cnt counts modulo 2*DELAY. sel = cnt / DELAY (0 or 1), evaluated before the increment.
//  - Datapath on each advance (lanes complex; re and im treated identically):
//      dl  = lower input delayed DELAY advances
//      sel=0: su = in_u, sl = dl;   sel=1: su = dl, sl = in_u
//      A   = su delayed DELAY advances; B = sl (undelayed)
//  - Outputs are registered. The A/B pair from advance n appears the cycle after, with out_valid=1,
//    if that advance produced a pair.
//  - out_valid is 0 on every other cycle. out_a/out_b hold their last value while out_valid=0.
//  - Advance index k counts from the last time the block left IDLE. Advances k = 0..DELAY-1 fill the
//    delay lines and produce no pair. Every advance from k = DELAY on produces a pair.
//  - FSM:
//      IDLE  -> FILL   on the first accepted pair
//      FILL  -> RUN    when the DELAY-th pair is accepted
//      FILL  -> IDLE   on flush (partial data discarded, cnt cleared, no output)
//      RUN   -> FLUSH  on flush. If in_valid=1 in the same cycle, that pair is accepted first
//                      (its output pair is still produced).
//      FLUSH           DELAY cycles, busy=1. Each cycle is an advance with in_u=in_l=0 and
//                      produces one valid pair.
//      FLUSH -> IDLE   after the DELAY-th flush cycle; cnt cleared.
//      flush in IDLE is ignored. flush during FLUSH has no effect.
//  - The drained output is only meaningful if the stream length is a multiple of 2*DELAY.
//    The block performs the flush sequence regardless.
//  - cnt wraps 2*DELAY-1 -> 0 with no effect on the FSM. Frames stream back to back without a bubble.
//  - Latency: the first pair is out DELAY advances + 1 clk after the first input.
//    In steady state, one pair per accepted input, 1 clk after it.
//  - No arithmetic. Data bits are copied exactly; no sign extension, rounding or saturation.
//  - Reset asserted mid-stream or mid-flush: everything returns to the reset state immediately.
//    No stale pairs are emitted afterwards.
// TESTING
//  1. DELAY=2, 8 back-to-back pairs. Upper lane = 1..8, lower lane = 11..18 (re=value, im=-value).
//     -> pairs from advances 2..7: (1,3) (2,4) (11,13) (12,14) (5,7) (6,8).
//     Then flush -> (15,17) (16,18) with busy=1 for 2 cycles, then IDLE.
//  2. Same stream with in_valid low every other cycle -> identical pair sequence,
//     each pair 1 clk after the accepting cycle.
//  3. DELAY=4, 64 consecutive pairs (8 wraps of cnt) -> no bubble; out_valid high continuously
//     from the cycle after pair 4.
//  4. DELAY=2: accept 1 pair, then flush -> no out_valid, IDLE next cycle.
//     Next stream behaves as in test 1.
//  5. Assert rst_n=0 during RUN (after 5 pairs) and during FLUSH -> outputs 0 and out_valid=0
//     immediately; test 1 then passes unchanged.
//  6. flush and in_valid together in RUN -> that pair is produced, then exactly DELAY flush pairs;
//     in_valid during busy is ignored.

Source files
------------

// File: rtl/r2mdc_commutator.sv
// R2MDC delay-commutator: reorders butterfly (upper, lower) lanes into next-stage A/B pairs; pair out 1 clk after its advance.
// No ready: gaps in in_valid stall all state; busy=1 while draining (in_valid ignored).
module r2mdc_commutator #(
    parameter int DATA_W = 16,
    parameter int DELAY  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_u_re,
    input  logic [DATA_W-1:0] in_u_im,
    input  logic [DATA_W-1:0] in_l_re,
    input  logic [DATA_W-1:0] in_l_im,
    input  logic              flush,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a_re,
    output logic [DATA_W-1:0] out_a_im,
    output logic [DATA_W-1:0] out_b_re,
    output logic [DATA_W-1:0] out_b_im
);
    localparam int CW = $clog2(2 * DELAY);
    localparam int FW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int SW = 2 * DATA_W;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [FW-1:0] fcnt_q;
    logic [SW-1:0] dl_q [DELAY];
    logic [SW-1:0] al_q [DELAY];
    logic [SW-1:0] out_a_q;
    logic [SW-1:0] out_b_q;
    logic          out_valid_q;

    logic          fill_abort;
    logic          accept;
    logic          advance;
    logic          produce;
    logic          sel;
    logic          last_fill;
    logic [SW-1:0] u_in;
    logic [SW-1:0] l_in;
    logic [SW-1:0] dl_out;
    logic [SW-1:0] su;
    logic [SW-1:0] sl;

    // A flush while still filling discards the partial frame, including any pair offered with it.
    assign fill_abort = (state_q == ST_FILL) && flush;
    assign accept     = in_valid && (state_q != ST_FLUSH) && !fill_abort;
    assign advance    = accept || (state_q == ST_FLUSH);
    assign produce    = advance && ((state_q == ST_RUN) || (state_q == ST_FLUSH));
    assign last_fill  = (cnt_q == CW'(DELAY - 1));

    // 2*DELAY is a power of two, so the counter MSB is cnt / DELAY.
    assign sel    = cnt_q[CW-1];
    assign u_in   = (state_q == ST_FLUSH) ? '0 : {in_u_re, in_u_im};
    assign l_in   = (state_q == ST_FLUSH) ? '0 : {in_l_re, in_l_im};
    assign dl_out = dl_q[DELAY-1];
    assign su     = sel ? dl_out : u_in;
    assign sl     = sel ? u_in : dl_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < DELAY; i++) begin
                dl_q[i] <= '0;
                al_q[i] <= '0;
            end
        end else begin
            if (advance) begin
                dl_q[0] <= l_in;
                al_q[0] <= su;
                for (int i = 1; i < DELAY; i++) begin
                    dl_q[i] <= dl_q[i-1];
                    al_q[i] <= al_q[i-1];
                end
                cnt_q <= cnt_q + CW'(1);
            end

            out_valid_q <= produce;
            if (produce) begin
                out_a_q <= al_q[DELAY-1];
                out_b_q <= sl;
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= last_fill ? ST_RUN : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_abort) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (accept && last_fill) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_FLUSH;
                        fcnt_q  <= '0;
                    end
                end
                ST_FLUSH: begin
                    fcnt_q <= fcnt_q + FW'(1);
                    if (fcnt_q == FW'(DELAY - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ST_FLUSH);
    assign out_valid = out_valid_q;
    assign out_a_re  = out_a_q[SW-1:DATA_W];
    assign out_a_im  = out_a_q[DATA_W-1:0];
    assign out_b_re  = out_b_q[SW-1:DATA_W];
    assign out_b_im  = out_b_q[DATA_W-1:0];

endmodule
